// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX/MEM pipeline register with branch resolution, redirect and wrong-path squash.
// Optional MISALIGN_TRAP_EN: taken control transfers to non-word-aligned targets trap instead of redirecting.
module ex_mem_branch_stage #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  carry,
    input  logic                  zero,
    input  logic                  overflow,
    input  logic                  negative,
    input  logic                  is_branch,
    input  logic                  is_jump,
    input  logic [2:0]            branch_funct3,
    input  logic [WIDTH-1:0]      target_pc,
    input  logic [WIDTH-1:0]      pc_plus4,
    input  logic [WIDTH-1:0]      store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            result_src,
    output logic                  mem_valid,
    output logic [WIDTH-1:0]      mem_alu_result,
    output logic [WIDTH-1:0]      mem_store_data,
    output logic [WIDTH-1:0]      mem_pc_plus4,
    output logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic [1:0]            mem_result_src,
    output logic                  redirect,
    output logic [WIDTH-1:0]      redirect_pc,
    output logic                  misalign_trap
);
    typedef enum logic {NORMAL, SHADOW} state_t;

    state_t                state_q;
    logic                  valid_q, reg_write_q, mem_read_q, mem_write_q, redirect_q, trap_q;
    logic [WIDTH-1:0]      alu_q, store_q, pc4_q, redirect_pc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            result_src_q;
    logic                  lt, cond, taken, misalign, go;

    // Signed less-than from a SUB: result sign corrected by overflow.
    assign lt = negative ^ overflow;

    always_comb begin
        cond = branch_funct3 == 3'b000 ? zero   :
               branch_funct3 == 3'b001 ? ~zero  :
               branch_funct3 == 3'b100 ? lt     :
               branch_funct3 == 3'b101 ? ~lt    :
               branch_funct3 == 3'b110 ? ~carry :
               branch_funct3 == 3'b111 ? carry  : 1'b0;
        taken = is_jump | (is_branch & cond);
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = taken & (target_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign go = ex_valid & taken & ~misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            redirect_q    <= 1'b0;
            trap_q        <= 1'b0;
            alu_q         <= '0;
            store_q       <= '0;
            pc4_q         <= '0;
            redirect_pc_q <= '0;
            rd_q          <= '0;
            result_src_q  <= '0;
        end else if (flush) begin
            state_q     <= NORMAL;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            redirect_q  <= 1'b0;
            trap_q      <= 1'b0;
        end else if (stall) begin
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
        end else if (state_q == SHADOW) begin
            // Wrong-path slot: drop it; only a real instruction ends the shadow.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            redirect_q  <= 1'b0;
            trap_q      <= 1'b0;
            if (ex_valid) state_q <= NORMAL;
        end else begin
            valid_q      <= ex_valid;
            alu_q        <= alu_result;
            store_q      <= store_data;
            pc4_q        <= pc_plus4;
            rd_q         <= rd_addr;
            result_src_q <= result_src;
            reg_write_q  <= reg_write & ex_valid & ~misalign;
            mem_read_q   <= mem_read & ex_valid & ~misalign;
            mem_write_q  <= mem_write & ex_valid & ~misalign;
            redirect_q   <= go;
            trap_q       <= ex_valid & misalign;
            if (go) begin
                redirect_pc_q <= target_pc;
                state_q       <= SHADOW;
            end
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_q;
    assign mem_store_data = store_q;
    assign mem_pc_plus4   = pc4_q;
    assign mem_rd_addr    = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_result_src = result_src_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign misalign_trap  = trap_q;
endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// tb_ex_mem_branch_stage: directed checks of capture, branch resolution, redirect, squash, stall and flush.
module tb_ex_mem_branch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid;
    logic [31:0] alu_result, target_pc, pc_plus4, store_data;
    logic        carry, zero, overflow, negative, is_branch, is_jump;
    logic [2:0]  branch_funct3;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_read, mem_write;
    logic [1:0]  result_src;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, redirect, misalign_trap;
    logic [31:0] mem_alu_result, mem_store_data, mem_pc_plus4, redirect_pc;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_result_src;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_branch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .alu_result(alu_result), .carry(carry), .zero(zero), .overflow(overflow), .negative(negative),
        .is_branch(is_branch), .is_jump(is_jump), .branch_funct3(branch_funct3), .target_pc(target_pc),
        .pc_plus4(pc_plus4), .store_data(store_data), .rd_addr(rd_addr), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .result_src(result_src), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_pc_plus4(mem_pc_plus4),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_result_src(mem_result_src), .redirect(redirect),
        .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
    );

    task automatic idle();
        rst = 0; stall = 0; flush = 0; ex_valid = 0; alu_result = 0; carry = 0; zero = 0;
        overflow = 0; negative = 0; is_branch = 0; is_jump = 0; branch_funct3 = 0; target_pc = 0;
        pc_plus4 = 0; store_data = 0; rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0; result_src = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input logic [31:0] alu);
        idle(); ex_valid = 1; alu_result = alu; reg_write = 1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; stall = 1; flush = 1; ex_valid = 1; reg_write = 1; is_jump = 1;
        step();
        checks++; if ({mem_valid, mem_alu_result, mem_store_data, mem_pc_plus4, mem_rd_addr, mem_reg_write, mem_mem_read, mem_mem_write, mem_result_src, redirect, redirect_pc, misalign_trap} !== '0)
            begin errors++; $display("FAIL reset_outputs: outputs not all zero (valid=%b redirect=%b alu=%h)", mem_valid, redirect, mem_alu_result); end
    endtask

    task automatic test_beq_taken();
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b000; zero = 1; alu_result = 0; target_pc = 32'h100;
        step();
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %b want 1", redirect); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL beq_redirect_pc: got %h want 00000100", redirect_pc); end
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL beq_mem_valid: got %b want 1", mem_valid); end
        plain(32'h55);
        step();
        checks++; if ({redirect, mem_valid, mem_reg_write} !== 3'b000) begin errors++; $display("FAIL beq_squash: got redirect/valid/rw=%b want 000", {redirect, mem_valid, mem_reg_write}); end
        step();
        checks++; if ({mem_valid, mem_reg_write, mem_alu_result} !== {2'b11, 32'h55}) begin errors++; $display("FAIL beq_after_shadow: got valid=%b rw=%b alu=%h want 1 1 00000055", mem_valid, mem_reg_write, mem_alu_result); end
    endtask

    task automatic test_blt_not_taken();
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b100; negative = 1; overflow = 1; alu_result = 32'hDEAD;
        target_pc = 32'h180; store_data = 32'h1234; rd_addr = 5'd7;
        step();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL blt_redirect: got %b want 0", redirect); end
        checks++; if ({mem_valid, mem_alu_result, mem_store_data, mem_rd_addr} !== {1'b1, 32'hDEAD, 32'h1234, 5'd7}) begin errors++; $display("FAIL blt_capture: got valid=%b alu=%h sd=%h rd=%0d want 1 0000dead 00001234 7", mem_valid, mem_alu_result, mem_store_data, mem_rd_addr); end
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b010; zero = 1; carry = 1;
        step();
        checks++; if ({redirect, mem_valid} !== 2'b01) begin errors++; $display("FAIL f3_010_not_taken: got redirect/valid=%b want 01", {redirect, mem_valid}); end
        idle(); ex_valid = 1; branch_funct3 = 3'b000; zero = 1;
        step();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL non_branch_not_taken: got %b want 0", redirect); end
    endtask

    task automatic test_bltu_bgeu();
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b110; carry = 0; target_pc = 32'h200;
        step();
        checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h200}) begin errors++; $display("FAIL bltu_taken: got redirect=%b pc=%h want 1 00000200", redirect, redirect_pc); end
        plain(32'h1);
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bltu_squash: got %b want 0", mem_valid); end
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b111; carry = 0; target_pc = 32'h300;
        step();
        checks++; if ({redirect, mem_valid, redirect_pc} !== {2'b01, 32'h200}) begin errors++; $display("FAIL bgeu_not_taken: got redirect=%b valid=%b pc=%h want 0 1 00000200", redirect, mem_valid, redirect_pc); end
    endtask

    task automatic test_stall_after_jal();
        idle(); ex_valid = 1; is_jump = 1; target_pc = 32'h300; alu_result = 32'h11; rd_addr = 5'd1;
        reg_write = 1; result_src = 2'd2; pc_plus4 = 32'h44;
        step();
        checks++; if ({redirect, mem_valid, mem_rd_addr, mem_result_src, mem_pc_plus4} !== {2'b11, 5'd1, 2'd2, 32'h44}) begin errors++; $display("FAIL jal_capture: got redirect=%b valid=%b rd=%0d rs=%0d pc4=%h want 1 1 1 2 00000044", redirect, mem_valid, mem_rd_addr, mem_result_src, mem_pc_plus4); end
        plain(32'h99); stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({redirect, mem_valid, mem_reg_write, mem_alu_result} !== {3'b011, 32'h11}) begin errors++; $display("FAIL jal_stall_hold%0d: got redirect=%b valid=%b rw=%b alu=%h want 0 1 1 00000011", i, redirect, mem_valid, mem_reg_write, mem_alu_result); end
        end
        stall = 0;
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL jal_squash_after_stall: got %b want 0", mem_valid); end
        plain(32'h77);
        step();
        checks++; if ({mem_valid, mem_alu_result} !== {1'b1, 32'h77}) begin errors++; $display("FAIL jal_resume: got valid=%b alu=%h want 1 00000077", mem_valid, mem_alu_result); end
    endtask

    task automatic test_flush_stall();
        idle(); ex_valid = 1; reg_write = 1; mem_write = 1; mem_read = 1; flush = 1; stall = 1; is_jump = 1; target_pc = 32'h500;
        step();
        checks++; if ({mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, redirect} !== 5'b0) begin errors++; $display("FAIL flush_stall: got valid/rw/mw/mr/redirect=%b want 00000", {mem_valid, mem_reg_write, mem_mem_write, mem_mem_read, redirect}); end
        plain(32'h88);
        step();
        checks++; if ({mem_valid, mem_alu_result} !== {1'b1, 32'h88}) begin errors++; $display("FAIL flush_no_shadow: got valid=%b alu=%h want 1 00000088", mem_valid, mem_alu_result); end
    endtask

    task automatic test_back_to_back();
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b001; zero = 0; target_pc = 32'h400;
        step();
        checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h400}) begin errors++; $display("FAIL b2b_first: got redirect=%b pc=%h want 1 00000400", redirect, redirect_pc); end
        target_pc = 32'h500;
        step();
        checks++; if ({redirect, mem_valid, redirect_pc} !== {2'b00, 32'h400}) begin errors++; $display("FAIL b2b_second: got redirect=%b valid=%b pc=%h want 0 0 00000400", redirect, mem_valid, redirect_pc); end
    endtask

    task automatic test_shadow_bubble();
        idle(); ex_valid = 1; is_branch = 1; branch_funct3 = 3'b101; negative = 1; overflow = 1; target_pc = 32'h600;
        step();
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL bge_taken: got %b want 1", redirect); end
        idle();
        step();
        plain(32'h1);
        step();
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL shadow_after_bubble: got %b want 0", mem_valid); end
        plain(32'h2);
        step();
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL shadow_exit: got %b want 1", mem_valid); end
    endtask

    task automatic test_reset_mid_shadow();
        idle(); ex_valid = 1; is_jump = 1; target_pc = 32'h700; reg_write = 1; alu_result = 32'h3;
        step();
        rst = 1;
        step();
        checks++; if ({mem_valid, mem_alu_result, mem_reg_write, redirect, redirect_pc} !== '0) begin errors++; $display("FAIL reset_mid_shadow: got valid=%b alu=%h redirect=%b pc=%h want zeros", mem_valid, mem_alu_result, redirect, redirect_pc); end
        plain(32'h2);
        step();
        checks++; if ({mem_valid, mem_alu_result} !== {1'b1, 32'h2}) begin errors++; $display("FAIL after_reset_capture: got valid=%b alu=%h want 1 00000002", mem_valid, mem_alu_result); end
    endtask

    task automatic test_misalign();
        idle(); ex_valid = 1; is_jump = 1; target_pc = 32'h102; reg_write = 1; mem_write = 1;
        step();
`ifdef MISALIGN_TRAP_EN
        checks++; if ({misalign_trap, redirect, mem_reg_write, mem_mem_write, mem_valid} !== 5'b10001) begin errors++; $display("FAIL misalign_trap: got trap/redirect/rw/mw/valid=%b want 10001", {misalign_trap, redirect, mem_reg_write, mem_mem_write, mem_valid}); end
        plain(32'h5);
        step();
        checks++; if ({misalign_trap, mem_valid} !== 2'b01) begin errors++; $display("FAIL misalign_no_shadow: got trap/valid=%b want 01", {misalign_trap, mem_valid}); end
`else
        checks++; if ({misalign_trap, redirect, redirect_pc, mem_reg_write} !== {2'b01, 32'h102, 1'b1}) begin errors++; $display("FAIL misalign_disabled: got trap=%b redirect=%b pc=%h rw=%b want 0 1 00000102 1", misalign_trap, redirect, redirect_pc, mem_reg_write); end
        plain(32'h5);
        step();
        checks++; if ({misalign_trap, redirect, mem_valid} !== 3'b000) begin errors++; $display("FAIL misalign_disabled_squash: got trap/redirect/valid=%b want 000", {misalign_trap, redirect, mem_valid}); end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_beq_taken();
        test_blt_not_taken();
        test_bltu_bgeu();
        test_stall_after_jal();
        test_flush_stall();
        test_back_to_back();
        test_shadow_bubble();
        test_reset_mid_shadow();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
